// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: oversample strobe, baud strobe and
// a 50%-duty baud clock, with glitch-free divisor reload and RX resync.
module baud_tick_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OS       = 16,
  parameter int DEF_INT  = 6,
  parameter int DEF_FRAC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_baud_tick,
  output logic              o_clk,
  output logic              o_load_pend
);

  localparam int OW = $clog2(OS);

  localparam logic [DIV_W-1:0] DEF_I =
    (DEF_INT < 2) ? DIV_W'(2) : DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_F = FRAC_W'(DEF_FRAC);
  localparam logic [OW-1:0] LAST = OW'(OS - 1);
  localparam logic [OW-1:0] HALF_M1 = OW'(OS / 2 - 1);

  function automatic logic [DIV_W-1:0] clamp(
    input logic [DIV_W-1:0] v
  );
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              load_pend;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [OW-1:0]     os_idx;
  logic              clk_q;

  logic              tick;
  logic              take;
  logic [DIV_W-1:0]  in_int;
  logic [DIV_W-1:0]  nxt_int;
  logic [FRAC_W-1:0] nxt_frac;
  logic [FRAC_W:0]   sum;

  assign in_int = clamp(i_div_int);
  assign tick   = i_en & ~i_resync & (cnt == '0);

  // Pending divisor lands on a tick boundary or whenever the counter is idle.
  assign take = load_pend & (tick | ~i_en);

  always_comb begin
    nxt_int  = act_int;
    nxt_frac = act_frac;
    if (i_resync && i_div_load) begin
      nxt_int  = in_int;
      nxt_frac = i_div_frac;
    end else if (take) begin
      nxt_int  = pend_int;
      nxt_frac = pend_frac;
    end
  end

  assign sum = {1'b0, acc} + {1'b0, nxt_frac};

  assign o_os_tick   = tick & ~i_rst;
  assign o_baud_tick = o_os_tick & (os_idx == LAST);
  assign o_clk       = clk_q;
  assign o_load_pend = load_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_int   <= DEF_I;
      act_frac  <= DEF_F;
      pend_int  <= DEF_I;
      pend_frac <= DEF_F;
      load_pend <= 1'b0;
      cnt       <= DEF_I - DIV_W'(1);
      acc       <= '0;
      os_idx    <= '0;
      clk_q     <= 1'b0;
    end else begin
      act_int  <= nxt_int;
      act_frac <= nxt_frac;

      if (i_div_load) begin
        pend_int  <= in_int;
        pend_frac <= i_div_frac;
        load_pend <= ~i_resync;
      end else if (take) begin
        load_pend <= 1'b0;
      end

      if (i_resync) begin
        cnt    <= nxt_int - DIV_W'(1);
        acc    <= '0;
        os_idx <= '0;
        clk_q  <= 1'b1;
      end else if (tick) begin
        cnt    <= sum[FRAC_W] ? nxt_int : nxt_int - DIV_W'(1);
        acc    <= sum[FRAC_W-1:0];
        os_idx <= os_idx + OW'(1);
        if (os_idx == LAST)
          clk_q <= 1'b1;
        else if (os_idx == HALF_M1)
          clk_q <= 1'b0;
      end else if (i_en) begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule
